// File: rtl/rf_writeback_arbiter.sv
// Register file writeback arbiter.
// Round-robin arbitration between the ALU pipe and the LSU into a one-entry
// registered stage that drives the register file write port. The staged
// write is forwarded to both read ports so same-cycle readers see it, and a
// stall input freezes the stage for a debug/dump agent.
module rf_writeback_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_fwd_hit,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic              rs2_fwd_hit,
  output logic [DATA_W-1:0] rs2_fwd_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              r_stage_valid;
  logic [ADDR_W-1:0] r_stage_rd;
  logic [DATA_W-1:0] r_stage_data;
  logic              r_last_grant;  // 0 = ALU, 1 = LSU
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic w_stage_free;
  logic w_grant_alu;
  logic w_grant_lsu;
  logic w_hs_alu;
  logic w_hs_lsu;
  logic w_conflict;

  // Stage accepts a new entry whenever it is empty or draining this cycle.
  always_comb begin
    w_stage_free = !r_stage_valid || !rf_stall;
    w_conflict   = alu_valid && lsu_valid;
    // Under contention the requester that did not win last time goes first.
    w_grant_alu  = alu_valid && (!lsu_valid || r_last_grant);
    w_grant_lsu  = lsu_valid && (!alu_valid || !r_last_grant);
    alu_ready    = w_grant_alu && w_stage_free;
    lsu_ready    = w_grant_lsu && w_stage_free;
    w_hs_alu     = alu_valid && alu_ready;
    w_hs_lsu     = lsu_valid && lsu_ready;
  end

  // Write port and forwarding views of the stage; x0 never writes or forwards.
  always_comb begin
    rf_we        = r_stage_valid && !rf_stall && (r_stage_rd != '0);
    rf_waddr     = r_stage_rd;
    rf_wdata     = r_stage_data;
    rs1_fwd_hit  = r_stage_valid && (r_stage_rd == rs1_addr) && (rs1_addr != '0);
    rs2_fwd_hit  = r_stage_valid && (r_stage_rd == rs2_addr) && (rs2_addr != '0);
    rs1_fwd_data = r_stage_data;
    rs2_fwd_data = r_stage_data;
    conflict_cnt = r_conflict_cnt;
  end

  // Output stage: load on handshake, empty on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage_valid <= 1'b0;
      r_stage_rd    <= '0;
      r_stage_data  <= '0;
      r_last_grant  <= 1'b1;
    end else if (w_hs_alu) begin
      r_stage_valid <= 1'b1;
      r_stage_rd    <= alu_rd;
      r_stage_data  <= alu_data;
      r_last_grant  <= 1'b0;
    end else if (w_hs_lsu) begin
      r_stage_valid <= 1'b1;
      r_stage_rd    <= lsu_rd;
      r_stage_data  <= lsu_data;
      r_last_grant  <= 1'b1;
    end else if (w_stage_free) begin
      r_stage_valid <= 1'b0;
    end
  end

  // Saturating count of cycles with both requesters valid, stall or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios followed by random
// traffic, every cycle checked against a behavioural model of the stage.
// A second instance with a 4-bit counter exposes counter saturation.
module tb_rf_writeback_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, lsu_valid, rf_stall;
  logic [AW-1:0] alu_rd, lsu_rd, rs1_addr, rs2_addr;
  logic [DW-1:0] alu_data, lsu_data;

  logic          alu_ready, lsu_ready, rf_we, rs1_fwd_hit, rs2_fwd_hit;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, rs1_fwd_data, rs2_fwd_data;
  logic [15:0]   conflict_cnt;

  logic          s_alu_ready, s_lsu_ready, s_rf_we, s_rs1_fwd_hit, s_rs2_fwd_hit;
  logic [AW-1:0] s_rf_waddr;
  logic [DW-1:0] s_rf_wdata, s_rs1_fwd_data, s_rs2_fwd_data;
  logic [3:0]    s_conflict_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model of the stage contents and arbitration history.
  bit            m_valid;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  bit            m_lsu_last;
  int unsigned   m_cnt, m_cnt4;
  bit            alu_pend, lsu_pend;

  always #5 clk = ~clk;

  rf_writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_fwd_hit(rs1_fwd_hit), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_hit(rs2_fwd_hit), .rs2_fwd_data(rs2_fwd_data),
    .conflict_cnt(conflict_cnt)
  );

  rf_writeback_arbiter #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(s_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(s_lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_stall(rf_stall), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_fwd_hit(s_rs1_fwd_hit), .rs1_fwd_data(s_rs1_fwd_data),
    .rs2_fwd_hit(s_rs2_fwd_hit), .rs2_fwd_data(s_rs2_fwd_data),
    .conflict_cnt(s_conflict_cnt)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                       input bit st, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input bit rst);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    rf_stall = st; rs1_addr = r1; rs2_addr = r2; reset = rst;
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] r1);
    drive(0, 0, 0, 0, 0, 0, 0, r1, 0, 0);
  endtask

  // One clock: compare every output against the model mid-cycle, then advance
  // the model by what the requesters and the stage should do at the edge.
  task automatic step();
    bit free, winner_lsu, exp_ar, exp_lr, exp_we, both;
    @(negedge clk);
    free = !m_valid || !rf_stall;
    both = alu_valid && lsu_valid;
    if (both) winner_lsu = !m_lsu_last;
    else      winner_lsu = lsu_valid;
    exp_ar = free && alu_valid && !winner_lsu;
    exp_lr = free && lsu_valid && winner_lsu;
    exp_we = m_valid && !rf_stall && (m_rd != 0);
    chk("alu_ready", alu_ready, exp_ar);
    chk("lsu_ready", lsu_ready, exp_lr);
    chk("rf_we", rf_we, exp_we);
    chk("rf_waddr", rf_waddr, m_rd);
    chk("rf_wdata", rf_wdata, m_data);
    chk("rs1_fwd_hit", rs1_fwd_hit, m_valid && m_rd == rs1_addr && rs1_addr != 0);
    chk("rs1_fwd_data", rs1_fwd_data, m_data);
    chk("rs2_fwd_hit", rs2_fwd_hit, m_valid && m_rd == rs2_addr && rs2_addr != 0);
    chk("rs2_fwd_data", rs2_fwd_data, m_data);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("conflict_cnt4", s_conflict_cnt, m_cnt4);
    chk("rf_we_cnt4inst", s_rf_we, exp_we);
    alu_pend = !reset && alu_valid && !exp_ar;
    lsu_pend = !reset && lsu_valid && !exp_lr;
    if (reset) begin
      m_valid = 0; m_rd = 0; m_data = 0; m_lsu_last = 1; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (both) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (exp_ar) begin
        m_valid = 1; m_rd = alu_rd; m_data = alu_data; m_lsu_last = 0;
      end else if (exp_lr) begin
        m_valid = 1; m_rd = lsu_rd; m_data = lsu_data; m_lsu_last = 1;
      end else if (free) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    m_valid = 0; m_rd = 0; m_data = 0; m_lsu_last = 1; m_cnt = 0; m_cnt4 = 0;
    alu_pend = 0; lsu_pend = 0;
    do_reset();

    // Reset state.
    idle(0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_cnt", conflict_cnt, 0);
    step();

    // ALU only.
    drive(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_only_ready", alu_ready, 1);
    chk("alu_only_lsu_ready", lsu_ready, 0);
    step();
    idle(5);
    chk("alu_only_we", rf_we, 1);
    chk("alu_only_waddr", rf_waddr, 5);
    chk("alu_only_wdata", rf_wdata, 64'h1234);
    chk("alu_only_fwd", rs1_fwd_hit, 1);
    step();

    // Contention from reset: ALU, LSU, ALU, LSU.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 64'hA1, 1, 2, 64'hB2, 0, 0, 0, 0);
      chk("cont_alu_ready", alu_ready, (i % 2) == 0);
      chk("cont_lsu_ready", lsu_ready, (i % 2) == 1);
      if (i > 0) chk("cont_waddr", rf_waddr, (i % 2) == 1 ? 1 : 2);
      step();
    end
    idle(0);
    chk("cont_waddr_last", rf_waddr, 2);
    chk("cont_cnt", conflict_cnt, 4);
    step();

    // Stall with rd=7 held in the stage.
    drive(1, 7, 64'h77, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 64'h99, 0, 0, 0, 1, 7, 0, 0);
      chk("stall_we", rf_we, 0);
      chk("stall_alu_ready", alu_ready, 0);
      chk("stall_fwd_hit", rs1_fwd_hit, 1);
      chk("stall_fwd_data", rs1_fwd_data, 64'h77);
      step();
    end
    drive(1, 9, 64'h99, 0, 0, 0, 0, 7, 0, 0);
    chk("unstall_we", rf_we, 1);
    chk("unstall_waddr", rf_waddr, 7);
    chk("unstall_alu_ready", alu_ready, 1);
    step();
    idle(0);
    step();

    // Write to x0.
    drive(0, 0, 0, 1, 0, 64'hFF, 0, 0, 0, 0);
    chk("x0_lsu_ready", lsu_ready, 1);
    step();
    idle(0);
    chk("x0_we", rf_we, 0);
    chk("x0_fwd", rs1_fwd_hit, 0);
    step();

    // Saturation of the 4-bit counter instance.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(1, 4, 64'h4, 1, 6, 64'h6, 0, 0, 0, 0);
      step();
    end
    idle(0);
    chk("sat_cnt4", s_conflict_cnt, 15);
    chk("sat_cnt16", conflict_cnt, 21);
    step();

    // Reset with a pending entry.
    drive(1, 3, 64'h33, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 3, 3, 1);
    step();
    idle(3);
    chk("rstmid_we", rf_we, 0);
    chk("rstmid_fwd", rs1_fwd_hit, 0);
    step();
    drive(1, 8, 64'h88, 1, 9, 64'h99, 0, 0, 0, 0);
    chk("rstmid_alu_first", alu_ready, 1);
    chk("rstmid_lsu_wait", lsu_ready, 0);
    step();

    // Random traffic; a requester holds its request until it is accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!alu_pend) begin
        alu_valid = $urandom_range(0, 2) != 0;
        alu_rd    = AW'($urandom_range(0, 7));
        alu_data  = {$urandom, $urandom};
      end
      if (!lsu_pend) begin
        lsu_valid = $urandom_range(0, 2) != 0;
        lsu_rd    = AW'($urandom_range(0, 7));
        lsu_data  = {$urandom, $urandom};
      end
      rf_stall = $urandom_range(0, 3) == 0;
      rs1_addr = AW'($urandom_range(0, 7));
      rs2_addr = AW'($urandom_range(0, 7));
      reset    = $urandom_range(0, 199) == 0;
      #1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
